// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/forwarding controller.
// Scoreboard entries carry register indices up to SB_WR_W bits wide; REG_AW must not exceed it.
package pipe_hazard_ctrl_pkg;

   localparam int REG_AW_DEF     = 5;
   localparam int DEPTH_DEF      = 3;
   localparam int LOAD_STAGE_DEF = 2;
   localparam int SB_WR_W        = 8;
   localparam int FWD_RF         = 0;

   typedef struct packed {
      logic               valid;
      logic               we;
      logic [SB_WR_W-1:0] wr;
      logic               is_load;
   } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_pick.sv
// Combinational priority finder: the youngest scoreboard stage writing i_rs wins,
// and a hazard is flagged when that winner is a load not yet forwardable.
module hazard_fwd_pick
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int DEPTH      = DEPTH_DEF,
   parameter int LOAD_STAGE = LOAD_STAGE_DEF,
   parameter int FWD_W      = $clog2(DEPTH + 1)
) (
   input  logic                    i_used,
   input  logic [SB_WR_W-1:0]      i_rs,
   input  sb_entry_t [DEPTH-1:0]   i_sb,
   output logic [FWD_W-1:0]        o_sel,
   output logic                    o_hazard
);

   always_comb begin
      o_sel    = FWD_W'(FWD_RF);
      o_hazard = 1'b0;
      if (i_used && (i_rs != '0)) begin
         // Walk oldest to youngest so a younger match overrides any older one.
         for (int k = DEPTH; k >= 1; k--) begin
            if (i_sb[k-1].valid && i_sb[k-1].we && (i_sb[k-1].wr == i_rs)) begin
               o_sel    = FWD_W'(k);
               o_hazard = i_sb[k-1].is_load && (k < LOAD_STAGE);
            end
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: scoreboard of in-flight writers from EX to WB.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW     = REG_AW_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int LOAD_STAGE = LOAD_STAGE_DEF,
   parameter int CNT_W      = 32,
   localparam int FWD_W     = $clog2(DEPTH + 1)
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              id_we,
   input  logic [REG_AW-1:0] id_wr,
   input  logic              id_is_load,
   input  logic              ex_redirect,
   output logic              stall_if,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic [FWD_W-1:0]  fwd_sel1,
   output logic [FWD_W-1:0]  fwd_sel2,
`ifdef HAZARD_PERF_EN
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
`endif
   output logic [DEPTH-1:0]  pipe_valid
);

   sb_entry_t [DEPTH-1:0] r_sb;
   sb_entry_t             w_new;
   logic [FWD_W-1:0]      w_sel1;
   logic [FWD_W-1:0]      w_sel2;
   logic                  w_haz1;
   logic                  w_haz2;
   logic                  w_stall;

   hazard_fwd_pick #(
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .FWD_W      (FWD_W)
   ) u_pick_rs1 (
      .i_used   (id_rs1_used),
      .i_rs     (SB_WR_W'(id_rs1)),
      .i_sb     (r_sb),
      .o_sel    (w_sel1),
      .o_hazard (w_haz1)
   );

   hazard_fwd_pick #(
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .FWD_W      (FWD_W)
   ) u_pick_rs2 (
      .i_used   (id_rs2_used),
      .i_rs     (SB_WR_W'(id_rs2)),
      .i_sb     (r_sb),
      .o_sel    (w_sel2),
      .o_hazard (w_haz2)
   );

   // A redirect squashes the wrong-path ID instruction, so it never stalls.
   assign w_stall    = id_valid && (w_haz1 || w_haz2) && !ex_redirect && !cpu_rst;
   assign stall_if   = w_stall;
   assign flush_ifid = ex_redirect && !cpu_rst;
   assign flush_idex = w_stall || flush_ifid;
   assign fwd_sel1   = (w_stall || cpu_rst) ? FWD_W'(FWD_RF) : w_sel1;
   assign fwd_sel2   = (w_stall || cpu_rst) ? FWD_W'(FWD_RF) : w_sel2;

   always_comb begin
      w_new = '0;
      if (!w_stall && !ex_redirect) begin
         w_new.valid   = id_valid;
         w_new.we      = id_we && (id_wr != '0);
         w_new.wr      = SB_WR_W'(id_wr);
         w_new.is_load = id_is_load;
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_sb <= '0;
      end else begin
         r_sb[0] <= w_new;
         for (int k = 1; k < DEPTH; k++) begin
            r_sb[k] <= r_sb[k-1];
         end
      end
   end

   always_comb begin
      pipe_valid = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pipe_valid[k] = r_sb[k].valid;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (ex_redirect) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a DEPTH=4/LOAD_STAGE=3 instance
// sharing the same ID stimulus. Counter checks are compiled when HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic       id_we;
   logic [4:0] id_wr;
   logic       id_is_load;
   logic       ex_redirect;

   logic       stall0, fifd0, fidx0;
   logic [1:0] f1_0, f2_0;
   logic [2:0] pv0;
   logic       stall4, fifd4, fidx4;
   logic [2:0] f1_4, f2_4;
   logic [3:0] pv4;
`ifdef HAZARD_PERF_EN
   logic [31:0] scnt0, fcnt0, scnt4, fcnt4;
`endif

   int n_chk = 0;
   int n_err = 0;

   pipe_hazard_ctrl dut0 (
      .cpu_clk     (clk),
      .cpu_rst     (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .id_we       (id_we),
      .id_wr       (id_wr),
      .id_is_load  (id_is_load),
      .ex_redirect (ex_redirect),
      .stall_if    (stall0),
      .flush_ifid  (fifd0),
      .flush_idex  (fidx0),
      .fwd_sel1    (f1_0),
      .fwd_sel2    (f2_0),
`ifdef HAZARD_PERF_EN
      .stall_cnt   (scnt0),
      .flush_cnt   (fcnt0),
`endif
      .pipe_valid  (pv0)
   );

   pipe_hazard_ctrl #(.DEPTH(4), .LOAD_STAGE(3)) dut4 (
      .cpu_clk     (clk),
      .cpu_rst     (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .id_we       (id_we),
      .id_wr       (id_wr),
      .id_is_load  (id_is_load),
      .ex_redirect (ex_redirect),
      .stall_if    (stall4),
      .flush_ifid  (fifd4),
      .flush_idex  (fidx4),
      .fwd_sel1    (f1_4),
      .fwd_sel2    (f2_4),
`ifdef HAZARD_PERF_EN
      .stall_cnt   (scnt4),
      .flush_cnt   (fcnt4),
`endif
      .pipe_valid  (pv4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic we,
                         input logic [4:0] wr, input logic ld, input logic redir);
      id_valid    = v;
      id_rs1      = rs1;
      id_rs1_used = u1;
      id_rs2      = rs2;
      id_rs2_used = u2;
      id_we       = we;
      id_wr       = wr;
      id_is_load  = ld;
      ex_redirect = redir;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_pv0", pv0, 0);
      chk("rst_pv4", pv4, 0);
      chk("rst_stall", stall0, 0);
      chk("rst_fidx", fidx0, 0);
      @(negedge clk);
      rst = 1'b0;

      // back-to-back ALU dependency
      step(); set_id(1, 0, 0, 0, 0, 1, 5, 0, 0); #1;
      chk("alu_wr_stall", stall0, 0);
      step(); set_id(1, 5, 1, 0, 0, 0, 0, 0, 0); #1;
      chk("alu_fwd1", f1_0, 1);
      chk("alu_stall", stall0, 0);
      chk("alu_pv", pv0, 3'b001);
      chk("alu_fwd1_d4", f1_4, 1);
      drain(5);

      // load-use, with DEPTH=4 sweep on the same stimulus
      step(); set_id(1, 0, 0, 0, 0, 1, 6, 1, 0);
      step(); set_id(1, 0, 0, 6, 1, 0, 0, 0, 0); #1;
      chk("lu_stall", stall0, 1);
      chk("lu_fidx", fidx0, 1);
      chk("lu_fifd", fifd0, 0);
      chk("lu_fwd2_dc", f2_0, 0);
      chk("sw_stall_c1", stall4, 1);
      step(); #1;
      chk("lu_stall_c2", stall0, 0);
      chk("lu_fwd2", f2_0, 2);
      chk("lu_fidx_c2", fidx0, 0);
      chk("sw_stall_c2", stall4, 1);
      step(); #1;
      chk("sw_stall_c3", stall4, 0);
      chk("sw_fwd2", f2_4, 3);
`ifdef HAZARD_PERF_EN
      chk("lu_scnt", scnt0, 1);
      chk("sw_scnt", scnt4, 2);
`endif
      drain(5);

      // youngest wins; older non-matching entry does not mask
      step(); set_id(1, 0, 0, 0, 0, 1, 7, 0, 0);
      step(); set_id(1, 0, 0, 0, 0, 1, 9, 0, 0);
      step(); set_id(1, 0, 0, 0, 0, 1, 7, 0, 0);
      step(); set_id(1, 7, 1, 9, 1, 0, 0, 0, 0); #1;
      chk("yw_fwd1", f1_0, 1);
      chk("yw_fwd2", f2_0, 2);
      chk("yw_stall", stall0, 0);
      chk("yw_fwd1_d4", f1_4, 1);
      drain(5);

      // x0 load in flight never forwards or stalls
      step(); set_id(1, 0, 0, 0, 0, 1, 0, 1, 0);
      step(); set_id(1, 0, 1, 0, 1, 0, 0, 0, 0); #1;
      chk("x0_fwd1", f1_0, 0);
      chk("x0_fwd2", f2_0, 0);
      chk("x0_stall", stall0, 0);
      chk("x0_pv", pv0, 3'b001);
      drain(5);

      // both sources hazardous -> one stall
      step(); set_id(1, 0, 0, 0, 0, 1, 6, 1, 0);
      step(); set_id(1, 6, 1, 6, 1, 0, 0, 0, 0); #1;
      chk("two_stall", stall0, 1);
      chk("two_fwd1", f1_0, 0);
      step(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
`ifdef HAZARD_PERF_EN
      chk("two_scnt", scnt0, 2);
`endif
      drain(5);

      // redirect beats load-use stall
      step(); set_id(1, 0, 0, 0, 0, 1, 6, 1, 0);
      step(); set_id(1, 0, 0, 6, 1, 0, 0, 0, 1); #1;
      chk("rd_stall", stall0, 0);
      chk("rd_fifd", fifd0, 1);
      chk("rd_fidx", fidx0, 1);
      step(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("rd_pv", pv0, 3'b010);
      chk("rd_fifd_off", fifd0, 0);
`ifdef HAZARD_PERF_EN
      chk("rd_fcnt", fcnt0, 1);
      chk("rd_scnt", scnt0, 2);
`endif
      drain(5);

      // async reset mid-cycle with a load at e[2]
      step(); set_id(1, 0, 0, 0, 0, 1, 6, 1, 0);
      step(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(); set_id(1, 6, 1, 0, 0, 0, 0, 0, 0); #1;
      chk("ar_pv_pre", pv0, 3'b010);
      chk("ar_stall4_pre", stall4, 1);
      rst = 1'b1;
      #1;
      chk("ar_pv0", pv0, 0);
      chk("ar_pv4", pv4, 0);
      chk("ar_stall4", stall4, 0);
      chk("ar_fidx4", fidx4, 0);
      chk("ar_fwd1", f1_0, 0);
`ifdef HAZARD_PERF_EN
      chk("ar_scnt", scnt0, 0);
      chk("ar_fcnt", fcnt0, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      set_id(1, 0, 0, 0, 0, 1, 5, 0, 0);
      step(); #1;
      chk("ar_first_edge", pv0, 3'b001);
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline: tracks every in-flight register writer from EX to WB in a scoreboard shift register. Each cycle it produces operand-forwarding selects for the instruction in ID, a load-use stall, and branch/jump flushes. It replaces hard-wired EX/MEM/WB comparisons, so stage count and load latency become parameters. It sits beside the controller and drives the PC, IF_ID and ID_EX hold/flush inputs plus the ID-stage operand muxes.

## Interface
- REG_AW, 5, register index width
- DEPTH, 3, tracked stages after ID (1 = EX … DEPTH = WB)
- LOAD_STAGE, 2, first stage index (1..DEPTH) at which load data is forwardable
- CNT_W, 32, performance counter width
- FWD_W (local), $clog2(DEPTH+1), forwarding select width
- cpu_clk  in  1  clock, rising edge
- cpu_rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1 / id_rs2  in  REG_AW  source indices
- id_rs1_used / id_rs2_used  in  1  source actually read
- id_we  in  1  ID instruction writes rf
- id_wr  in  REG_AW  ID destination
- id_is_load  in  1  ID instruction is a load
- ex_redirect  in  1  taken branch/jump resolved in EX
- stall_if  out  1  hold PC and IF_ID
- flush_ifid  out  1  clear IF_ID to nop
- flush_idex  out  1  load bubble into ID_EX
- fwd_sel1 / fwd_sel2  out  FWD_W  0 = register file, k = forward from stage k
- pipe_valid  out  DEPTH  scoreboard valid bits, bit k-1 = stage k
- stall_cnt / flush_cnt  out  CNT_W  only with HAZARD_PERF_EN

## Operation
- Entry e[k] = {valid, we, wr, is_load}; writes with wr = 0 are recorded with we = 0.
- Source match: used && rs ≠ 0 && e[k].valid && e[k].we && e[k].wr == rs; the smallest matching k (youngest) wins.
- Forwarding: fwd_sel = k of the winning match, else 0.
- Load-use hazard: the winning entry is a load with k < LOAD_STAGE.
- stall = id_valid && hazard on either source && !ex_redirect.
- Stall response: stall_if=1, flush_idex=1, fwd_sel is don't-care (driven 0).
- Redirect: flush_ifid=1, flush_idex=1, stall_if=0; redirect beats stall because the ID instruction is wrong-path.
- Shift each edge: e[k+1] ← e[k]; e[DEPTH] retires.
- Shift into e[1]: {id_valid,id_we&&id_wr≠0,id_wr,id_is_load}, or all-zero when stall or redirect.
- An older non-matching entry never masks a younger match. Two hazardous sources produce one stall, not two.

## Timing
- stall_if, flush_*, fwd_sel are combinational from state and ID inputs: zero latency, same cycle.
- Scoreboard updates on rising cpu_clk. A dependent behind a load at e[1] stalls LOAD_STAGE−1 cycles, then forwards from LOAD_STAGE.
- Defaults give a 1-cycle load-use stall and forwarding from EX, MEM or WB.
- Reset (async, any time, mid-stall included): all entries invalid, pipe_valid=0, stall_if=0, flush_*=0, fwd_sel*=0, counters 0. The first edge after deassertion samples normally.

## Configuration
- HAZARD_PERF_EN defined: stall_cnt increments each cycle stall_if=1; flush_cnt increments each cycle ex_redirect=1. Both counters wrap at 2^CNT_W and the ports exist.
- HAZARD_PERF_EN undefined: counters and ports are absent, and functional behaviour is identical.

## Structure
- Shared package holds:
  - FWD_RF = 0 constant;
  - sb_entry_t typedef {valid, we, wr, is_load};
  - default REG_AW/DEPTH/LOAD_STAGE.
- Sub-module hazard_fwd_pick: combinational priority finder over the scoreboard. It is instantiated twice (rs1, rs2) and returns {sel, hazard}.

## Test plan
- Back-to-back ALU dependency: e[1] = {1,1,x5,0}, ID reads rs1=x5 → fwd_sel1=1, stall_if=0.
- Load-use: load x6 in e[1], ID reads rs2=x6 → stall_if=1, flush_idex=1 for 1 cycle; next cycle fwd_sel2=2, stall_if=0; stall_cnt=1.
- Youngest wins: x7 written at e[1] and e[3], ID reads x7 → fwd_sel1=1. x0 source with an x0 writer in flight → fwd_sel=0, no stall.
- Redirect during load-use: ex_redirect=1 while a hazard is present → stall_if=0, flush_ifid=1, flush_idex=1; next e[1] invalid; flush_cnt=1.
- Async reset while a load sits in e[2]: assert cpu_rst mid-cycle → pipe_valid=0 immediately, all outputs 0, counters 0.
- Parameter sweep DEPTH=4, LOAD_STAGE=3: load at e[1] with dependent in ID → 2 stall cycles, then fwd_sel=3.
